// File: rtl/stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : stream_checker
// Description : Paced sink that checks an incrementing payload stream,
//               counting beats and mismatches, with stall timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_checker #(
    parameter int                    DATA_WIDTH  = 128,
    parameter int                    NUM_DATA    = 2000,
    parameter int                    DATA_RATE   = 1,
    parameter logic [DATA_WIDTH-1:0] START_VALUE = '0,
    parameter int                    STALL_LIMIT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  valid,
    output logic                  ready,
    output logic [31:0]           rcv_cnt,
    output logic [31:0]           err_cnt,
    output logic [31:0]           first_err_idx,
    output logic [DATA_WIDTH-1:0] first_err_data,
    output logic                  done,
    output logic                  timeout,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_DONE    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    localparam int                RATE_W       = (DATA_RATE > 1) ? $clog2(DATA_RATE) : 1;
    localparam logic [RATE_W-1:0] C_RATE_TOP   = RATE_W'(DATA_RATE - 1);
    localparam logic [31:0]       C_STALL_TOP  = 32'(STALL_LIMIT);
    localparam logic [31:0]       C_NUM_DATA   = 32'(NUM_DATA);

    state_t                  state_q, state_d;
    logic [RATE_W-1:0]       rate_cnt_q, rate_cnt_d;
    logic [31:0]             stall_cnt_q, stall_cnt_d;
    logic [31:0]             rcv_cnt_q, rcv_cnt_d;
    logic [31:0]             err_cnt_q, err_cnt_d;
    logic [31:0]             first_err_idx_q, first_err_idx_d;
    logic [DATA_WIDTH-1:0]   first_err_data_q, first_err_data_d;
    logic [DATA_WIDTH-1:0]   expected_q, expected_d;
    logic                    w_accept;

    // ready is a function of registered state only so upstream may wait on it
    assign ready    = (state_q == S_RUN) && (rate_cnt_q == C_RATE_TOP);
    assign w_accept = valid && ready;

    always_comb begin
        state_d          = state_q;
        rate_cnt_d       = rate_cnt_q;
        stall_cnt_d      = stall_cnt_q;
        rcv_cnt_d        = rcv_cnt_q;
        err_cnt_d        = err_cnt_q;
        first_err_idx_d  = first_err_idx_q;
        first_err_data_d = first_err_data_q;
        expected_d       = expected_q;

        case (state_q)
            S_RUN: begin
                if (w_accept) begin
                    rate_cnt_d  = '0;
                    stall_cnt_d = '0;
                    rcv_cnt_d   = rcv_cnt_q + 32'd1;
                    expected_d  = expected_q + 1'b1;
                    if (data != expected_q) begin
                        if (err_cnt_q != 32'hFFFF_FFFF) begin
                            err_cnt_d = err_cnt_q + 32'd1;
                        end
                        // err_cnt saturates, so zero means no mismatch yet this run
                        if (err_cnt_q == 32'd0) begin
                            first_err_idx_d  = rcv_cnt_q;
                            first_err_data_d = data;
                        end
                    end
                    if (rcv_cnt_d == C_NUM_DATA) begin
                        state_d = S_DONE;
                    end
                end else begin
                    if (rate_cnt_q != C_RATE_TOP) begin
                        rate_cnt_d = rate_cnt_q + 1'b1;
                    end
                    stall_cnt_d = stall_cnt_q + 32'd1;
                    if (stall_cnt_d == C_STALL_TOP) begin
                        state_d = S_TIMEOUT;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d          = S_RUN;
                    rate_cnt_d       = '0;
                    stall_cnt_d      = '0;
                    rcv_cnt_d        = '0;
                    err_cnt_d        = '0;
                    first_err_idx_d  = '0;
                    first_err_data_d = '0;
                    expected_d       = START_VALUE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            rate_cnt_q       <= '0;
            stall_cnt_q      <= '0;
            rcv_cnt_q        <= '0;
            err_cnt_q        <= '0;
            first_err_idx_q  <= '0;
            first_err_data_q <= '0;
            expected_q       <= START_VALUE;
        end else begin
            state_q          <= state_d;
            rate_cnt_q       <= rate_cnt_d;
            stall_cnt_q      <= stall_cnt_d;
            rcv_cnt_q        <= rcv_cnt_d;
            err_cnt_q        <= err_cnt_d;
            first_err_idx_q  <= first_err_idx_d;
            first_err_data_q <= first_err_data_d;
            expected_q       <= expected_d;
        end
    end

    assign rcv_cnt        = rcv_cnt_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_idx  = first_err_idx_q;
    assign first_err_data = first_err_data_q;
    assign done           = (state_q == S_DONE);
    assign timeout        = (state_q == S_TIMEOUT);
    assign state          = state_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_checker
// Description : Self-checking bench for stream_checker against a queue-based
//               reference model, plus paced/wrapping directed run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_checker;

    localparam int A_W     = 16;
    localparam int A_NUM   = 2000;
    localparam int A_RATE  = 1;
    localparam int A_STALL = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: long runs, errors, timeout, async reset
    logic            a_rst, a_start, a_valid;
    logic [A_W-1:0]  a_data;
    logic            a_ready, a_done, a_tmo;
    logic [31:0]     a_rcv, a_err, a_fidx;
    logic [A_W-1:0]  a_fdata;
    logic [1:0]      a_state;

    // instance B: paced, 8-bit wrapping stream
    logic            b_rst, b_start, b_valid;
    logic [7:0]      b_data;
    logic            b_ready, b_done, b_tmo;
    logic [31:0]     b_rcv, b_err, b_fidx;
    logic [7:0]      b_fdata;
    logic [1:0]      b_state;

    stream_checker #(
        .DATA_WIDTH (A_W),
        .NUM_DATA   (A_NUM),
        .DATA_RATE  (A_RATE),
        .START_VALUE(16'h0000),
        .STALL_LIMIT(A_STALL)
    ) u_a (
        .clk(clk), .reset(a_rst), .start(a_start), .data(a_data), .valid(a_valid),
        .ready(a_ready), .rcv_cnt(a_rcv), .err_cnt(a_err), .first_err_idx(a_fidx),
        .first_err_data(a_fdata), .done(a_done), .timeout(a_tmo), .state(a_state)
    );

    stream_checker #(
        .DATA_WIDTH (8),
        .NUM_DATA   (4),
        .DATA_RATE  (3),
        .START_VALUE(8'hFE),
        .STALL_LIMIT(16)
    ) u_b (
        .clk(clk), .reset(b_rst), .start(b_start), .data(b_data), .valid(b_valid),
        .ready(b_ready), .rcv_cnt(b_rcv), .err_cnt(b_err), .first_err_idx(b_fidx),
        .first_err_data(b_fdata), .done(b_done), .timeout(b_tmo), .state(b_state)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: run phase, cycles since run start / last accept,
    // and the list of every payload accepted in the current run.
    int             m_st;
    int             m_gap;
    logic [A_W-1:0] m_q[$];

    task automatic m_reset();
        m_st  = 0;
        m_gap = 0;
        m_q.delete();
    endtask

    function automatic bit m_ready();
        return (m_st == 1) && (m_gap >= A_RATE - 1);
    endfunction

    task automatic m_scan(output int errs, output int fidx, output logic [A_W-1:0] fdata);
        errs  = 0;
        fidx  = 0;
        fdata = '0;
        foreach (m_q[i]) begin
            if (m_q[i] != A_W'(i)) begin
                if (errs == 0) begin
                    fidx  = i;
                    fdata = m_q[i];
                end
                errs++;
            end
        end
    endtask

    // Compare instance A with the model, then advance one clock.
    task automatic step();
        int             errs, fidx;
        logic [A_W-1:0] fdata;
        bit             acc;
        m_scan(errs, fidx, fdata);
        chk("a_state", a_state, m_st);
        chk("a_ready", a_ready, m_ready());
        chk("a_rcv",   a_rcv,   m_q.size());
        chk("a_err",   a_err,   errs);
        chk("a_fidx",  a_fidx,  fidx);
        chk("a_fdata", a_fdata, fdata);
        chk("a_done",  a_done,  m_st == 2);
        chk("a_tmo",   a_tmo,   m_st == 3);
        acc = a_valid && m_ready();
        @(posedge clk);
        if (m_st == 1) begin
            if (acc) begin
                m_q.push_back(a_data);
                m_gap = 0;
                if (m_q.size() == A_NUM) m_st = 2;
            end else begin
                m_gap++;
                if (m_gap == A_STALL) m_st = 3;
            end
        end else if (a_start) begin
            m_st  = 1;
            m_gap = 0;
            m_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int g, n, b_acc;
        a_rst = 1'b0; a_start = 1'b0; a_valid = 1'b0; a_data = '0;
        b_rst = 1'b0; b_start = 1'b0; b_valid = 1'b0; b_data = '0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_state", a_state, 0);
        chk("rst_ready", a_ready, 0);
        chk("rst_rcv",   a_rcv,   0);
        a_rst = 1'b1;
        b_rst = 1'b1;

        // no run without start, valid ignored in IDLE
        a_valid = 1'b1;
        repeat (4) step();
        chk("idle_hold", a_state, 0);
        a_valid = 1'b0;

        // paced 8-bit run: ready one cycle in three, expected wraps FE..01
        b_valid = 1'b1;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        b_acc = 0;
        for (int c = 0; c < 15; c++) begin
            b_data = 8'(8'hFE + b_acc);
            chk("b_ready", b_ready, (c < 12) && (c % 3 == 2));
            chk("b_state", b_state, (c < 12) ? 1 : 2);
            if (b_ready) b_acc++;
            step();
        end
        chk("b_rcv",  b_rcv,  4);
        chk("b_err",  b_err,  0);
        chk("b_done", b_done, 1);
        chk("b_tmo",  b_tmo,  0);
        chk("b_fidx", b_fidx, 0);
        chk("b_fdat", b_fdata, 0);

        // run 1: clean stream, valid held high
        a_valid = 1'b1;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        g = 0;
        while (a_rcv < A_NUM && g < 3000) begin
            a_data = a_rcv[A_W-1:0];
            step();
            g++;
        end
        chk("r1_bound", g < 3000, 1);
        chk("r1_rcv",   a_rcv,  2000);
        chk("r1_err",   a_err,  0);
        chk("r1_done",  a_done, 1);
        repeat (5) begin
            chk("r1_rdy_low", a_ready, 0);
            step();
        end

        // run 2: random valid, stray starts, beats 5 and 9 corrupted
        a_start = 1'b1;
        step();
        g = 0;
        while (a_done !== 1'b1 && g < 6000) begin
            a_valid = ($urandom % 4) != 0;
            a_start = ($urandom % 50) == 0;
            if (a_rcv == 5)      a_data = 16'hDEAD;
            else if (a_rcv == 9) a_data = 16'h1234;
            else                 a_data = a_rcv[A_W-1:0];
            step();
            g++;
        end
        a_start = 1'b0;
        chk("r2_bound", g < 6000, 1);
        chk("r2_err",   a_err,   2);
        chk("r2_fidx",  a_fidx,  5);
        chk("r2_fdata", a_fdata, 16'hDEAD);

        // run 3: 10 beats then stall into timeout
        a_valid = 1'b1;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        g = 0;
        while (a_rcv < 10 && g < 50) begin
            a_data = a_rcv[A_W-1:0];
            step();
            g++;
        end
        a_valid = 1'b0;
        n = 0;
        while (a_tmo !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("r3_tmo_lat", n, 16);
        chk("r3_rcv", a_rcv, 10);
        a_valid = 1'b1;
        repeat (4) step();
        chk("r3_frozen", a_rcv, 10);
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk("r3_restart", a_state, 1);
        chk("r3_clr",     a_rcv,   0);

        // run 4: async reset in the middle of a run
        g = 0;
        while (a_rcv < 700 && g < 1000) begin
            a_data = a_rcv[A_W-1:0];
            step();
            g++;
        end
        chk("r4_rcv", a_rcv, 700);
        #2 a_rst = 1'b0;
        #1;
        chk("r4_ready", a_ready, 0);
        chk("r4_state", a_state, 0);
        chk("r4_rcv0",  a_rcv,   0);
        chk("r4_err0",  a_err,   0);
        chk("r4_fidx0", a_fidx,  0);
        chk("r4_fdat0", a_fdata, 0);
        chk("r4_done0", a_done,  0);
        chk("r4_tmo0",  a_tmo,   0);
        m_reset();
        @(negedge clk);
        a_rst = 1'b1;
        repeat (5) step();
        chk("r4_idle", a_state, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_checker.md
STREAM_CHECKER -- requirements
Module: stream_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, width of the checked payload.
REQ-002 SHALL have parameter NUM_DATA, default 2000, number of beats expected per run.
REQ-003 SHALL have parameter DATA_RATE, default 1, minimum cycles between accepted beats (>=1).
REQ-004 SHALL have parameter START_VALUE, default 0, expected value of the first beat.
REQ-005 SHALL have parameter STALL_LIMIT, default 1024, RUN cycles without an accept before timeout (>=1).
REQ-006 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  input  1  single-cycle request to begin or restart a run.
REQ-009 SHALL have port data  input  DATA_WIDTH  payload from the upstream sender.
REQ-010 SHALL have port valid  input  1  upstream payload valid.
REQ-011 SHALL have port ready  output  1  checker can accept this cycle.
REQ-012 SHALL have port rcv_cnt  output  32  beats accepted in the current run.
REQ-013 SHALL have port err_cnt  output  32  mismatching beats in the current run, saturating.
REQ-014 SHALL have port first_err_idx  output  32  rcv_cnt value at the first mismatch.
REQ-015 SHALL have port first_err_data  output  DATA_WIDTH  payload of the first mismatch.
REQ-016 SHALL have port done  output  1  run completed with NUM_DATA beats.
REQ-017 SHALL have port timeout  output  1  run aborted by stall.
REQ-018 SHALL have port state  output  2  FSM state: IDLE=0, RUN=1, DONE=2, TIMEOUT=3.

Function
REQ-019 SHALL leave IDLE for RUN on the edge where start=1; start SHALL be ignored while in RUN.
REQ-020 SHALL, on start in IDLE, DONE or TIMEOUT, clear rcv_cnt, err_cnt, first_err_idx, first_err_data, the rate counter and the stall counter; SHALL load expected to START_VALUE.
REQ-021 SHALL drive ready combinationally from registered state only: ready = (state==RUN) && (rate_cnt==DATA_RATE-1); ready SHALL never depend on valid.
REQ-022 SHALL count a beat as accepted only on a cycle with valid && ready.
REQ-023 SHALL increment rate_cnt each RUN cycle until it reaches DATA_RATE-1, hold it there, and return it to 0 on accept; DATA_RATE=1 gives ready high every RUN cycle.
REQ-024 SHALL, on accept, compare data with expected, increment rcv_cnt, and set expected <= expected+1, wrapping mod 2^DATA_WIDTH. Expected SHALL advance from its own value and SHALL NOT resynchronise to received data.
REQ-025 SHALL, on a mismatching accept, increment err_cnt, saturating at 32'hFFFFFFFF.
REQ-026 SHALL, on the first mismatch of a run only, capture first_err_idx = pre-increment rcv_cnt and first_err_data = data.
REQ-027 SHALL, on the accept making rcv_cnt equal NUM_DATA, go to DONE next cycle, with ready low from that cycle.
REQ-028 SHALL increment the stall counter each RUN cycle without an accept and clear it on accept.
REQ-029 SHALL enter TIMEOUT when the stall counter reaches STALL_LIMIT. If an accept occurs in the same cycle, the accept SHALL win and TIMEOUT SHALL NOT be entered.
REQ-030 SHALL hold done=(state==DONE) and timeout=(state==TIMEOUT); both are sticky until start or reset.
REQ-031 SHALL freeze all counters and capture registers in IDLE, DONE and TIMEOUT; valid in those states SHALL have no effect.

Reset
REQ-032 SHALL, while reset=0, asynchronously force state=IDLE, ready=0, done=0, timeout=0, rcv_cnt=0, err_cnt=0, first_err_idx=0, first_err_data=0, expected=START_VALUE, rate_cnt=0, stall_cnt=0.
REQ-033 SHALL abort a run on reset asserted mid-RUN: ready SHALL fall without waiting for a clk edge, and no partial beat SHALL be counted.
REQ-034 SHALL require start after reset release before entering RUN.

Verification
REQ-035 SHALL check: DATA_RATE=1, NUM_DATA=2000, sender with incrementing data 0..1999 and valid held high -> rcv_cnt=2000, err_cnt=0, done=1 one cycle after the 2000th accept, and ready low thereafter.
REQ-036 SHALL check: DATA_RATE=3 with valid always high -> ready high one cycle in three, and accepts at cycles 2, 5, 8 after start.
REQ-037 SHALL check: beat index 5 corrupted to 0xDEAD and beat 9 corrupted -> err_cnt=2, first_err_idx=5, first_err_data=0xDEAD.
REQ-038 SHALL check: STALL_LIMIT=16, valid low after 10 beats -> timeout=1 16 cycles after the last accept, rcv_cnt=10 frozen; then start -> RUN with counters cleared.
REQ-039 SHALL check: reset pulled low mid-run at rcv_cnt=700 -> ready=0 immediately and all outputs 0; after release, state stays IDLE until start.
REQ-040 SHALL check: DATA_WIDTH=8, START_VALUE=8'hFE, NUM_DATA=4, data FE, FF, 00, 01 -> err_cnt=0, confirming expected wraps.
